// File: rtl/cache_read_controller_pkg.sv
// Shared types and constants for the direct-mapped read cache controller.
package cache_pkg;

    localparam int OFFSET_W       = 2;
    localparam int WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        REFILL  = 2'd2,
        RESPOND = 2'd3
    } state_t;

endpackage

// File: rtl/cache_read_controller_if.sv
// CPU read port, flush/busy and memory refill bus of the read cache.
interface cache_read_controller_if #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 8
);
    logic              cpu_rd_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [WORD_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              flush;
    logic              busy;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output cpu_rd_req, cpu_addr, flush, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, busy, mem_rd_req, mem_addr
    );

    modport slave (
        input  cpu_rd_req, cpu_addr, flush, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, busy, mem_rd_req, mem_addr
    );

endinterface

// File: rtl/cache_read_controller_word_multiplexer.sv
// 4:1 selector of an 8-bit word within a cache line.
module word_multiplexer (
    input  logic [7:0] data0x,
    input  logic [7:0] data1x,
    input  logic [7:0] data2x,
    input  logic [7:0] data3x,
    input  logic [1:0] sel,
    output logic [7:0] result
);

    always_comb begin
        result = data0x;
        case (sel)
            2'd0: result = data0x;
            2'd1: result = data1x;
            2'd2: result = data2x;
            2'd3: result = data3x;
            default: result = data0x;
        endcase
    end

endmodule

// File: rtl/cache_read_controller.sv
// Direct-mapped read-only cache: tag/valid/data flops plus hit/miss/refill FSM.
//
// state   | meaning
// IDLE    | waiting for a request; applies direct or pending flush
// COMPARE | tag lookup; hit -> respond, miss -> start line refill
// REFILL  | fetching 4 words of the line, one beat per mem_ack
// RESPOND | cpu_ready pulse with registered read data
module cache_read_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INDEX_W = 3,
    parameter int WORD_W  = 8
) (
    input logic                     clk,
    input logic                     rst,
    cache_read_controller_if.slave  bus
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 2 ** INDEX_W;

    state_t state, state_nxt;

    logic [OFFSET_W-1:0] off;
    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;

    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_arr  [LINES];
    logic [WORD_W-1:0]   data_arr [LINES][WORDS_PER_LINE];

    logic [WORD_W-1:0]   cpu_rdata_q, cpu_rdata_nxt;
    logic                cpu_ready_q, cpu_ready_nxt;
    logic                mem_rd_req_q, mem_rd_req_nxt;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_nxt;
    logic [1:0]          word_cnt, word_cnt_nxt;
    logic                flush_pend, flush_pend_nxt;

    logic                hit;
    logic                clr_valid;
    logic                install;
    logic                data_we;
    logic [WORD_W-1:0]   mux_word;

    // Refill line location comes from the beat address so the install does not
    // depend on the CPU holding its address if it abandons the request.
    logic [INDEX_W-1:0]  ridx;
    logic [TAG_W-1:0]    rtag;

    assign off  = bus.cpu_addr[OFFSET_W-1:0];
    assign idx  = bus.cpu_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign tag  = bus.cpu_addr[ADDR_W-1:INDEX_W+OFFSET_W];
    assign ridx = mem_addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign rtag = mem_addr_q[ADDR_W-1:INDEX_W+OFFSET_W];

    assign hit = valid[idx] && (tag_arr[idx] == tag);

    word_multiplexer u_word_mux (
        .data0x (data_arr[idx][0]),
        .data1x (data_arr[idx][1]),
        .data2x (data_arr[idx][2]),
        .data3x (data_arr[idx][3]),
        .sel    (off),
        .result (mux_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cpu_rdata_q  <= '0;
            cpu_ready_q  <= 1'b0;
            mem_rd_req_q <= 1'b0;
            mem_addr_q   <= '0;
            word_cnt     <= '0;
            flush_pend   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cpu_rdata_q  <= cpu_rdata_nxt;
            cpu_ready_q  <= cpu_ready_nxt;
            mem_rd_req_q <= mem_rd_req_nxt;
            mem_addr_q   <= mem_addr_nxt;
            word_cnt     <= word_cnt_nxt;
            flush_pend   <= flush_pend_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cpu_rdata_nxt  = cpu_rdata_q;
        cpu_ready_nxt  = 1'b0;
        mem_rd_req_nxt = mem_rd_req_q;
        mem_addr_nxt   = mem_addr_q;
        word_cnt_nxt   = word_cnt;
        flush_pend_nxt = flush_pend | bus.flush;
        clr_valid      = 1'b0;
        install        = 1'b0;
        data_we        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.flush || flush_pend) begin
                    clr_valid      = 1'b1;
                    flush_pend_nxt = 1'b0;
                end else if (bus.cpu_rd_req) begin
                    state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                if (!bus.cpu_rd_req) begin
                    state_nxt = IDLE;
                end else if (hit) begin
                    cpu_rdata_nxt = mux_word;
                    cpu_ready_nxt = 1'b1;
                    state_nxt     = RESPOND;
                end else begin
                    word_cnt_nxt   = '0;
                    mem_rd_req_nxt = 1'b1;
                    mem_addr_nxt   = {tag, idx, 2'b00};
                    state_nxt      = REFILL;
                end
            end
            REFILL: begin
                if (bus.mem_ack && mem_rd_req_q) begin
                    data_we = 1'b1;
                    if (word_cnt != 2'd3) begin
                        word_cnt_nxt = word_cnt + 2'd1;
                        mem_addr_nxt = {mem_addr_q[ADDR_W-1:OFFSET_W], word_cnt + 2'd1};
                    end else begin
                        mem_rd_req_nxt = 1'b0;
                        install        = 1'b1;
                        state_nxt      = COMPARE;
                    end
                end
            end
            RESPOND: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (clr_valid) begin
            valid <= '0;
        end else if (install) begin
            valid[ridx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (install) begin
            tag_arr[ridx] <= rtag;
        end
        if (data_we) begin
            data_arr[ridx][word_cnt] <= bus.mem_rdata;
        end
    end

    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_ready  = cpu_ready_q;
    assign bus.mem_rd_req = mem_rd_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_cache_read_controller.sv
// Directed bench for cache_read_controller; memory returns ~addr after 0-3 waits.
module tb_cache_read_controller;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cache_read_controller_if #(.ADDR_W(8), .WORD_W(8)) bus ();

    cache_read_controller #(.ADDR_W(8), .INDEX_W(3), .WORD_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.mem_rdata = ~bus.mem_addr;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] beats [64];
    int         total = 0;
    int         wcnt;
    int         base;
    int         g;
    int         fb0;
    int         fg;
    logic       seen_ready;

    // Memory model: one beat per ack, each beat's address logged in order.
    initial begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_rd_req) begin
                if (wcnt == 0) begin
                    bus.mem_ack = 1'b1;
                    beats[total % 64] = bus.mem_addr;
                    total++;
                    wcnt = int'($urandom_range(0, 3));
                end else begin
                    wcnt--;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [7:0] a, output logic [7:0] d,
                           output int lat, output int b);
        @(posedge clk); #1;
        b = total;
        bus.cpu_addr   = a;
        bus.cpu_rd_req = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.cpu_ready && lat < 100);
        d = bus.cpu_rdata;
        bus.cpu_rd_req = 1'b0;
        chk($sformatf("no_timeout_%0h", a), 32'(lat < 100), 32'd1);
    endtask

    task automatic check_miss(input logic [7:0] a, input logic [7:0] expd);
        logic [7:0] d;
        int lat;
        int b;
        do_read(a, d, lat, b);
        chk($sformatf("miss_data_%0h", a), 32'(d), 32'(expd));
        chk($sformatf("miss_beats_%0h", a), 32'(total - b), 32'd4);
        chk($sformatf("miss_lat_%0h", a), 32'(lat >= 7), 32'd1);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] o;
            o = 2'(i);
            chk($sformatf("beat%0d_addr_%0h", i, a), 32'(beats[(b + i) % 64]), 32'({a[7:2], o}));
        end
    endtask

    task automatic check_hit(input logic [7:0] a, input logic [7:0] expd);
        logic [7:0] d;
        int lat;
        int b;
        do_read(a, d, lat, b);
        chk($sformatf("hit_data_%0h", a), 32'(d), 32'(expd));
        chk($sformatf("hit_beats_%0h", a), 32'(total - b), 32'd0);
        chk($sformatf("hit_lat_%0h", a), 32'(lat), 32'd2);
        @(posedge clk); #1;
        chk($sformatf("hit_ready_pulse_%0h", a), 32'(bus.cpu_ready), 32'd0);
        chk($sformatf("hit_data_held_%0h", a), 32'(bus.cpu_rdata), 32'(expd));
    endtask

    initial begin
        rst            = 1'b1;
        bus.cpu_rd_req = 1'b0;
        bus.cpu_addr   = '0;
        bus.flush      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst_mem_rd_req", 32'(bus.mem_rd_req), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // cold miss, hits in the same line, conflict eviction
        check_miss(8'h25, 8'hDA);
        check_hit(8'h27, 8'hD8);
        check_hit(8'h24, 8'hDB);
        check_miss(8'h45, 8'hBA);
        check_miss(8'h25, 8'hDA);

        // flush while idle
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_idle_busy", 32'(bus.busy), 32'd0);
        check_miss(8'h45, 8'hBA);
        check_hit(8'h45, 8'hBA);

        // flush during refill: response completes, line invalidated afterwards
        fb0 = total;
        fork
            check_miss(8'h61, 8'h9E);
            begin
                fg = 0;
                while (total == fb0 && fg < 100) begin
                    @(negedge clk);
                    fg++;
                end
                chk("flush_refill_state", 32'(bus.mem_rd_req), 32'd1);
                bus.flush = 1'b1;
                @(negedge clk);
                bus.flush = 1'b0;
            end
        join
        check_miss(8'h61, 8'h9E);

        // request abandoned during refill: line still installed, no response
        @(posedge clk); #1;
        base = total;
        bus.cpu_addr   = 8'h81;
        bus.cpu_rd_req = 1'b1;
        g = 0;
        while (total - base < 1 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        bus.cpu_rd_req = 1'b0;
        seen_ready = 1'b0;
        g = 0;
        while (bus.busy && g < 100) begin
            if (bus.cpu_ready) seen_ready = 1'b1;
            @(posedge clk); #1;
            g++;
        end
        chk("drop_no_ready", 32'(seen_ready | bus.cpu_ready), 32'd0);
        chk("drop_idle", 32'(bus.busy), 32'd0);
        chk("drop_beats", 32'(total - base), 32'd4);
        check_hit(8'h81, 8'h7E);

        // reset mid-refill after the second beat
        @(posedge clk); #1;
        base = total;
        bus.cpu_addr   = 8'hA9;
        bus.cpu_rd_req = 1'b1;
        g = 0;
        while (total - base < 2 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        chk("midrst_in_refill", 32'(bus.mem_rd_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_mem_rd_req", 32'(bus.mem_rd_req), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        bus.cpu_rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_miss(8'hA9, 8'h56);
        check_miss(8'h25, 8'hDA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
